rx_timing_ctrl: RTL and testbench

RX_TIMING_CTRL -- requirements
Module: rx_timing_ctrl

---
 rtl/rx_pkg.sv | 15 +
 rtl/rx_bit_timer.sv | 48 ++++
 rtl/rx_timing_ctrl.sv | 130 +++++++++++++
 tb/tb_rx_timing_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types and defaults for the UART receive timing controller.
package rx_pkg;

  localparam int CLKS_PER_BIT_DEF   = 10;
  localparam int BITS_PER_FRAME_DEF = 9;   // 8 data bits + stop bit
  localparam int DATA_WIDTH         = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_CHK = 2'd1,
    RECEIVE   = 2'd2,
    STOP_CHK  = 2'd3
  } rx_state_t;

endpackage : rx_pkg

// File: rtl/rx_bit_timer.sv
// Clock and bit counters for the receiver: half-bit start check, bit-centre
// shift strobes and an end-of-frame pulse.
module rx_bit_timer
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEF,
  parameter int BITS_PER_FRAME = BITS_PER_FRAME_DEF
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic receive,
  output logic half_point,
  output logic shift_strobe,
  output logic frame_done
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(BITS_PER_FRAME);
  localparam int HALF = CLKS_PER_BIT / 2;

  logic [CW-1:0] clk_cnt;
  logic [BW-1:0] bit_cnt;

  // The counter reads n-1 in the n-th cycle after a clear, so the
  // half-bit point of the start bit is HALF-1 after the edge cycle.
  assign half_point   = (clk_cnt == CW'(HALF - 1));
  assign shift_strobe = receive && (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign frame_done   = shift_strobe && (bit_cnt == BW'(BITS_PER_FRAME - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (shift_strobe) clk_cnt <= '0;
      else              clk_cnt <= clk_cnt + CW'(1);
      // The final strobe does not advance, keeping the count inside its width.
      if (shift_strobe && !frame_done) bit_cnt <= bit_cnt + BW'(1);
    end
  end

endmodule : rx_bit_timer

// File: rtl/rx_timing_ctrl.sv
// UART receive timing controller: start detection, bit-centre strobes for an
// external shift stage, and a one-byte receive buffer with error flags.
// Optional build macro RX_INPUT_SYNC_EN adds a two-flop input synchronizer.
// CLKS_PER_BIT must be even and at least 4.
module rx_timing_ctrl
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT   = CLKS_PER_BIT_DEF,
  parameter int BITS_PER_FRAME = BITS_PER_FRAME_DEF
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  serial_in,
  output logic                  serial_sync,
  output logic                  shift_strobe,
  input  logic [DATA_WIDTH-1:0] packet_data,
  input  logic                  stop_bit,
  input  logic                  data_read,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  data_ready,
  output logic                  overrun_error,
  output logic                  framing_error
);

  rx_state_t state, state_next;
  logic      prev_sync;
  logic      start_edge;
  logic      timer_clear;
  logic      receive;
  logic      stop_chk;
  logic      load;
  logic      half_point;
  logic      frame_done;

`ifdef RX_INPUT_SYNC_EN
  logic [1:0] sync_ff;

  // Reset high so a released reset looks like an idle line.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sync_ff <= 2'b11;
    else        sync_ff <= {sync_ff[0], serial_in};
  end

  assign serial_sync = sync_ff[1];
`else
  assign serial_sync = serial_in;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) prev_sync <= 1'b1;
    else        prev_sync <= serial_sync;
  end

  assign start_edge = prev_sync && !serial_sync;

  rx_bit_timer #(
    .CLKS_PER_BIT  (CLKS_PER_BIT),
    .BITS_PER_FRAME(BITS_PER_FRAME)
  ) u_bit_timer (
    .clk         (clk),
    .n_rst       (n_rst),
    .clear       (timer_clear),
    .receive     (receive),
    .half_point  (half_point),
    .shift_strobe(shift_strobe),
    .frame_done  (frame_done)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    timer_clear = 1'b0;
    receive     = 1'b0;
    stop_chk    = 1'b0;
    unique case (state)
      IDLE: begin
        timer_clear = 1'b1;
        if (start_edge) state_next = START_CHK;
      end
      START_CHK: begin
        if (half_point) begin
          if (!serial_sync) begin
            state_next  = RECEIVE;
            timer_clear = 1'b1;   // realign so strobes land on bit centres
          end else begin
            state_next  = IDLE;   // glitch, not a real start bit
          end
        end
      end
      RECEIVE: begin
        receive = 1'b1;
        if (frame_done) state_next = STOP_CHK;
      end
      STOP_CHK: begin
        stop_chk   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign load = stop_chk && stop_bit;

  // A same-cycle read acknowledges the old byte, so the new load is not an overrun.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (stop_chk) framing_error <= !stop_bit;
      if (load) begin
        rx_data       <= packet_data;
        data_ready    <= 1'b1;
        overrun_error <= data_ready && !data_read;
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
    end
  end

endmodule : rx_timing_ctrl

// File: tb/tb_rx_timing_ctrl.sv
// Directed self-checking bench for rx_timing_ctrl with a behavioural 9-bit shift stage.
module tb_rx_timing_ctrl;

  localparam int CPB = 10;
`ifdef RX_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       serial_in = 1'b1;
  logic       serial_sync;
  logic       shift_strobe;
  logic [7:0] packet_data;
  logic       stop_bit;
  logic       data_read = 1'b0;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;

  logic [8:0] shreg;
  int         cyc = 0;
  int         strobes[$];
  int         ready_rise = -1;
  logic       ready_q = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;
  int         ein;

  rx_timing_ctrl dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .serial_in    (serial_in),
    .serial_sync  (serial_sync),
    .shift_strobe (shift_strobe),
    .packet_data  (packet_data),
    .stop_bit     (stop_bit),
    .data_read    (data_read),
    .rx_data      (rx_data),
    .data_ready   (data_ready),
    .overrun_error(overrun_error),
    .framing_error(framing_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shift stage: LSB first, stop bit ends up in the top position.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst)            shreg <= '0;
    else if (shift_strobe) shreg <= {serial_sync, shreg[8:1]};
  end
  assign packet_data = shreg[7:0];
  assign stop_bit    = shreg[8];

  always @(negedge clk) begin
    if (shift_strobe) strobes.push_back(cyc);
    if (data_ready && !ready_q) ready_rise = cyc;
    ready_q = data_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_flags(input string tag, input logic [7:0] data, input logic rdy,
                             input logic ovr, input logic frm);
    check({tag, ".rx_data"}, 32'(rx_data), 32'(data));
    check({tag, ".data_ready"}, 32'(data_ready), 32'(rdy));
    check({tag, ".overrun"}, 32'(overrun_error), 32'(ovr));
    check({tag, ".framing"}, 32'(framing_error), 32'(frm));
  endtask

  // Strobes expected at E+15+10k where E is the serial_sync falling edge.
  task automatic check_strobes(input string tag, input int e_in, input int n_exp);
    check({tag, ".strobe_count"}, 32'(strobes.size()), 32'(n_exp));
    for (int k = 0; k < n_exp && k < strobes.size(); k++)
      check($sformatf("%s.strobe%0d", tag, k), 32'(strobes[k]), 32'(e_in + LAT + 15 + CPB * k));
  endtask

  // Drives one 100-cycle frame; optionally pulses data_read in the load cycle.
  task automatic send_frame(input logic [7:0] d, input logic stp, input bit rd_at_load,
                            output int e_in);
    logic [9:0] bits;
    bits = {stp, d, 1'b0};
    strobes.delete();
    e_in = cyc;
    for (int c = 0; c < 10 * CPB; c++) begin
      serial_in = bits[c / CPB];
      data_read = rd_at_load && (c == 96 + LAT);
      tick();
    end
    serial_in = 1'b1;
    data_read = 1'b0;
    repeat (6) tick();
  endtask

  task automatic pulse_read();
    data_read = 1'b1;
    tick();
    data_read = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    check("reset.strobe", 32'(shift_strobe), 32'd0);
    check_flags("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b1;
    repeat (4) tick();

    // Good frame 0x5A: strobe timing and load cycle.
    ready_rise = -1;
    send_frame(8'h5A, 1'b1, 1'b0, ein);
    check_strobes("f5a", ein, 9);
    check("f5a.ready_cycle", 32'(ready_rise), 32'(ein + LAT + 97));
    check_flags("f5a", 8'h5A, 1'b1, 1'b0, 1'b0);

    // Three-cycle glitch: rejected at the half-bit check.
    strobes.delete();
    serial_in = 1'b0;
    repeat (3) tick();
    serial_in = 1'b1;
    repeat (25) tick();
    check("glitch.strobe_count", 32'(strobes.size()), 32'd0);
    check_flags("glitch", 8'h5A, 1'b1, 1'b0, 1'b0);

    // Bad stop bit: only framing_error changes.
    send_frame(8'h3C, 1'b0, 1'b0, ein);
    check_strobes("bad", ein, 9);
    check_flags("bad", 8'h5A, 1'b1, 1'b0, 1'b1);

    pulse_read();
    check_flags("read1", 8'h5A, 1'b0, 1'b0, 1'b1);

    send_frame(8'hA5, 1'b1, 1'b0, ein);
    check_flags("fa5", 8'hA5, 1'b1, 1'b0, 1'b0);

    // Second byte without a read: overrun.
    send_frame(8'h81, 1'b1, 1'b0, ein);
    check_flags("ovr", 8'h81, 1'b1, 1'b1, 1'b0);
    pulse_read();
    check_flags("read2", 8'h81, 1'b0, 1'b0, 1'b0);

    // Read in the same cycle as a load over an unread byte.
    send_frame(8'h42, 1'b1, 1'b0, ein);
    check_flags("f42", 8'h42, 1'b1, 1'b0, 1'b0);
    send_frame(8'h24, 1'b1, 1'b1, ein);
    check_flags("same", 8'h24, 1'b1, 1'b0, 1'b0);

    send_frame(8'h11, 1'b0, 1'b0, ein);
    check_flags("bad2", 8'h24, 1'b1, 1'b0, 1'b1);

    // Reset at E+40 mid-frame.
    begin
      logic [9:0] bits;
      bits = {1'b1, 8'hF0, 1'b0};
      strobes.delete();
      ein = cyc;
      for (int c = 0; c < 40 + LAT; c++) begin
        serial_in = bits[c / CPB];
        tick();
      end
    end
    check("mid.strobe_count", 32'(strobes.size()), 32'd3);
    n_rst = 1'b0;
    serial_in = 1'b1;
    #1;
    check("mid_rst.strobe", 32'(shift_strobe), 32'd0);
    check_flags("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    n_rst = 1'b1;
    strobes.delete();
    repeat (100) tick();
    check("post_rst.strobe_count", 32'(strobes.size()), 32'd0);
    check_flags("post_rst", 8'h00, 1'b0, 1'b0, 1'b0);

    ready_rise = -1;
    send_frame(8'h99, 1'b1, 1'b0, ein);
    check_strobes("f99", ein, 9);
    check("f99.ready_cycle", 32'(ready_rise), 32'(ein + LAT + 97));
    check_flags("f99", 8'h99, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rx_timing_ctrl
